// File: rtl/pc_sequencer_pkg.sv
// pc_pkg: definitions shared by the program-counter sequencer and its fetch
// interface.
//   pc_state_t     : sequencer states (IDLE/RUN/HALT/FAULT)
//   XLEN           : address width of the program counter
//   INSTR_SENTINEL : instruction word that marks the end of a program
//   PC_STEP        : byte distance between consecutive instructions
//   sat_inc32      : increment that holds at all-ones instead of wrapping
package pc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        HALT  = 2'd2,
        FAULT = 2'd3
    } pc_state_t;

    localparam int          XLEN           = 64;
    localparam logic [31:0] INSTR_SENTINEL = 32'hFFFF_FFFF;
    localparam logic [63:0] PC_STEP        = 64'd4;

    // Counting beyond the maximum has no meaning for a retire counter, so it
    // sticks at the top value rather than rolling back to zero.
    function automatic logic [31:0] sat_inc32(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: fetch-side connection between the PC sequencer and the
// instruction_fetch block.
//   PC          : address presented by the sequencer
//   instruction : word stored at PC (combinational from the fetch side)
//   invAddr     : PC is misaligned or outside the instruction memory
// Modports:
//   master : sequencer side (drives PC)
//   slave  : fetch side (returns instruction and invAddr)
interface pc_sequencer_if;
    import pc_pkg::*;

    logic [XLEN-1:0] PC;
    logic [31:0]     instruction;
    logic            invAddr;

    modport master (
        output PC,
        input  instruction,
        input  invAddr
    );

    modport slave (
        input  PC,
        output instruction,
        output invAddr
    );

endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: holds the architectural program counter and steps it through
// the program using the instruction_fetch block as a combinational lookup.
// Ports:
//   clk, rst_n     : clock and asynchronous active-low reset
//   start          : begin from IDLE, or restart from HALT/FAULT
//   stall          : downstream not ready, PC holds
//   branch_taken   : redirect next PC to branch_target on an accept
//   branch_target  : redirect address, loaded without checks
//   fetch          : master side of the fetch interface (PC out,
//                    instruction/invAddr in)
//   instr_valid    : current instruction accepted this cycle (combinational)
//   halted, fault  : registered state flags
//   retired_count  : saturating count of accepted instructions
module pc_sequencer
    import pc_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter logic [31:0] SENTINEL = INSTR_SENTINEL
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 stall,
    input  logic                 branch_taken,
    input  logic [XLEN-1:0]      branch_target,
    pc_sequencer_if.master       fetch,
    output logic                 instr_valid,
    output logic                 halted,
    output logic                 fault,
    output logic [31:0]          retired_count
);

    pc_state_t       state_reg;
    logic [XLEN-1:0] pc_reg;
    logic            halted_reg;
    logic            fault_reg;
    logic [31:0]     count_reg;

    logic            is_sentinel;
    logic            accept;

    // The fetch result belongs to the current PC in the same cycle, so the
    // accept decision is purely combinational on top of registered state.
    assign is_sentinel = (fetch.instruction == SENTINEL);
    assign accept      = (state_reg == RUN) & ~fetch.invAddr & ~is_sentinel & ~stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            pc_reg     <= RESET_PC;
            halted_reg <= 1'b0;
            fault_reg  <= 1'b0;
            count_reg  <= 32'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    pc_reg <= RESET_PC;
                    if (start) begin
                        state_reg <= RUN;
                    end
                end

                RUN: begin
                    // Priority: bad address, then end of program, then stall.
                    if (fetch.invAddr) begin
                        state_reg <= FAULT;
                        fault_reg <= 1'b1;
                    end else if (is_sentinel) begin
                        state_reg  <= HALT;
                        halted_reg <= 1'b1;
                    end else if (accept) begin
                        count_reg <= sat_inc32(count_reg);
                        // No alignment check on the target: a bad target is
                        // caught by invAddr on the following cycle.
                        pc_reg    <= branch_taken ? branch_target : pc_reg + PC_STEP;
                    end
                end

                HALT, FAULT: begin
                    if (start) begin
                        state_reg  <= RUN;
                        pc_reg     <= RESET_PC;
                        count_reg  <= 32'd0;
                        halted_reg <= 1'b0;
                        fault_reg  <= 1'b0;
                    end
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign fetch.PC      = pc_reg;
    assign instr_valid   = accept;
    assign halted        = halted_reg;
    assign fault         = fault_reg;
    assign retired_count = count_reg;

endmodule
